seq_chunk_adder: RTL and testbench

- Multi-cycle, parametrised successor to the fixed 16-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, keeping the inter-chunk carry in a register.
- Trades latency for a short combinational path: only a CHUNK-bit ripple sits between flops.
- Operates as a start/done coprocessor on the datapath's arithmetic unit.

---
 rtl/seq_chunk_adder.sv | 149 ++++++++++++++
 tb/tb_seq_chunk_adder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract unit. It processes WIDTH-bit
// operands CHUNK bits per clock and keeps the inter-chunk carry in a register,
// so only a CHUNK-bit ripple sits between flops. Start/done handshake.
module seq_chunk_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_overflow
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic               r_carry;
    logic [IDX_W-1:0]   r_idx;
    logic [WIDTH-1:0]   r_psum;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_opa_nxt;
    logic [WIDTH-1:0]   w_opb_nxt;
    logic               w_carry_nxt;
    logic [IDX_W-1:0]   w_idx_nxt;
    logic [WIDTH-1:0]   w_psum_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_sum_nxt;
    logic               w_cout_nxt;
    logic               w_ovf_nxt;

    logic [31:0]        w_base;
    logic [CHUNK-1:0]   w_chunk_a;
    logic [CHUNK-1:0]   w_chunk_b;
    logic [CHUNK:0]     w_chunk_res;
    logic [WIDTH-1:0]   w_psum_merged;

    // Current chunk slice, its CHUNK-bit add, and the partial sum with it merged in
    always_comb begin
        w_base        = 32'(r_idx) * CHUNK;
        w_chunk_a     = CHUNK'(r_opa >> w_base);
        w_chunk_b     = CHUNK'(r_opb >> w_base);
        w_chunk_res   = (CHUNK+1)'(w_chunk_a) + (CHUNK+1)'(w_chunk_b) + (CHUNK+1)'(r_carry);
        w_psum_merged = (r_psum & ~(CHUNK_MASK << w_base))
                      | (WIDTH'(w_chunk_res[CHUNK-1:0]) << w_base);
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_opa_nxt   = r_opa;
        w_opb_nxt   = r_opb;
        w_carry_nxt = r_carry;
        w_idx_nxt   = r_idx;
        w_psum_nxt  = r_psum;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_sum_nxt   = r_sum;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_opa_nxt   = i_a;
                    w_opb_nxt   = i_sub ? ~i_b : i_b;
                    w_carry_nxt = i_sub ? 1'b1 : i_cin;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_psum_nxt  = w_psum_merged;
                w_carry_nxt = w_chunk_res[CHUNK];
                w_idx_nxt   = r_idx + IDX_W'(1);
                if (r_idx == LAST_IDX) begin
                    w_sum_nxt   = w_psum_merged;
                    w_cout_nxt  = w_chunk_res[CHUNK];
                    w_ovf_nxt   = (r_opa[WIDTH-1] == r_opb[WIDTH-1])
                               && (w_psum_merged[WIDTH-1] != r_opa[WIDTH-1]);
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_psum  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_opa   <= w_opa_nxt;
            r_opb   <= w_opb_nxt;
            r_carry <= w_carry_nxt;
            r_idx   <= w_idx_nxt;
            r_psum  <= w_psum_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sum   <= w_sum_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_sum      = r_sum;
    assign o_cout     = r_cout;
    assign o_overflow = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder: CHUNK=4 main instance plus CHUNK=1 and
// CHUNK=16 instances sharing the same stimulus for the parameter sweep.
module tb_seq_chunk_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, start, cin, sub;
    logic [15:0] a, b;

    logic        busy4, done4, cout4, ovf4;
    logic [15:0] sum4;
    logic        busy1, done1, cout1, ovf1;
    logic [15:0] sum1;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b),
        .i_cin(cin), .i_sub(sub), .o_busy(busy4), .o_done(done4),
        .o_sum(sum4), .o_cout(cout4), .o_overflow(ovf4));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b),
        .i_cin(cin), .i_sub(sub), .o_busy(busy1), .o_done(done1),
        .o_sum(sum1), .o_cout(cout1), .o_overflow(ovf1));

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b),
        .i_cin(cin), .i_sub(sub), .o_busy(busy16), .o_done(done16),
        .o_sum(sum16), .o_cout(cout16), .o_overflow(ovf16));

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic v);
        exp_t r;
        r.sum  = s;
        r.cout = c;
        r.ovf  = v;
        return r;
    endfunction

    // Reference: 17-bit add of A and (possibly inverted) B
    function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mc, input logic ms);
        logic [15:0] bb;
        logic [16:0] full;
        exp_t        r;
        bb     = ms ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, bb} + 17'(ms ? 1'b1 : mc);
        r.sum  = full[15:0];
        r.cout = full[16];
        r.ovf  = (ma[15] == bb[15]) && (full[15] != ma[15]);
        return r;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the start edge
    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tcin,
                            input logic tsub, input exp_t e);
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait for Done on the CHUNK=4 instance, then pop and compare
    task automatic wait_result(input string name, input int exp_lat, input int cyc0);
        int   cyc;
        int   busy_cyc;
        exp_t e;
        cyc = cyc0;
        busy_cyc = 0;
        while (!done4 && cyc < 40) begin
            if (busy4) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (done4 !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: no done after %0d cycles", name, cyc);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (sum4 !== e.sum) begin
            errors++;
            $display("FAIL %s sum: got %h expected %h", name, sum4, e.sum);
        end
        checks++;
        if (cout4 !== e.cout) begin
            errors++;
            $display("FAIL %s cout: got %b expected %b", name, cout4, e.cout);
        end
        checks++;
        if (ovf4 !== e.ovf) begin
            errors++;
            $display("FAIL %s overflow: got %b expected %b", name, ovf4, e.ovf);
        end
        checks++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, cyc, exp_lat);
        end
        checks++;
        if (busy_cyc !== exp_lat - cyc0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %0d busy cycles busy_at_done=%b expected %0d and 0",
                     name, busy_cyc, busy4, exp_lat - cyc0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 20'h0) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy4, done4, sum4, cout4, ovf4);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        logic [15:0] held;
        start_op(16'hA51B, 16'h52BB, 1'b0, 1'b0, mk(16'hF7D6, 1'b0, 1'b0));
        wait_result("basic_add", 4, 0);
        held = sum4;
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || sum4 !== 16'hF7D6 || sum4 !== held) begin
            errors++;
            $display("FAIL done_pulse: got done=%b sum=%h expected done=0 sum=f7d6", done4, sum4);
        end
    endtask

    task automatic test_back_to_back();
        start_op(16'h372D, 16'hF359, 1'b0, 1'b0, mk(16'h2A86, 1'b1, 1'b0));
        wait_result("b2b_first", 4, 0);
        start_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, mk(16'hFFFF, 1'b1, 1'b0));
        wait_result("b2b_second", 4, 0);
    endtask

    task automatic test_subtract();
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 1'b0, 1'b0));
        wait_result("sub_borrow", 4, 0);
        start_op(16'h0007, 16'h0005, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0));
        wait_result("sub_noborrow", 4, 0);
    endtask

    task automatic test_overflow();
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        wait_result("ovf_add", 4, 0);
        start_op(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1));
        wait_result("ovf_sub", 4, 0);
    endtask

    task automatic test_abort();
        int seen;
        start_op(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0));
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_result("ignore_start_in_run", 4, 2);
        start_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, mk(16'h1010, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        checks++;
        if ({busy4, done4, sum4, cout4, ovf4} !== 20'h0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b expected all 0",
                     busy4, done4, sum4, cout4, ovf4);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (done4 || busy4) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d cycles with done/busy expected 0", seen);
        end
        start_op(16'h4000, 16'h4000, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1));
        wait_result("after_abort", 4, 0);
    endtask

    task automatic test_sweep();
        logic [15:0] ra, rb;
        logic        rc, rs;
        exp_t        e;
        int          lat1, lat4, lat16;
        logic [17:0] r1, r4, r16;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int v = 0; v < 4; v++) begin
            if (v == 3) begin
                ra = 16'hFFFF; rb = 16'h0000; rc = 1'b1; rs = 1'b0;
            end else begin
                ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
            end
            start_op(ra, rb, rc, rs, (v == 3) ? mk(16'h0000, 1'b1, 1'b0) : model(ra, rb, rc, rs));
            lat1 = -1; lat4 = -1; lat16 = -1;
            r1 = '0; r4 = '0; r16 = '0;
            for (int cyc = 0; cyc < 20; cyc++) begin
                if (done1 && lat1 < 0)   begin lat1 = cyc;  r1  = {sum1, cout1, ovf1};   end
                if (done4 && lat4 < 0)   begin lat4 = cyc;  r4  = {sum4, cout4, ovf4};   end
                if (done16 && lat16 < 0) begin lat16 = cyc; r16 = {sum16, cout16, ovf16}; end
                @(negedge clk);
            end
            e = sb.pop_front();
            checks++;
            if (lat1 !== 16 || r1 !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL sweep_chunk1 v%0d: got lat=%0d res=%h expected lat=16 res=%h",
                         v, lat1, r1, {e.sum, e.cout, e.ovf});
            end
            checks++;
            if (lat4 !== 4 || r4 !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL sweep_chunk4 v%0d: got lat=%0d res=%h expected lat=4 res=%h",
                         v, lat4, r4, {e.sum, e.cout, e.ovf});
            end
            checks++;
            if (lat16 !== 1 || r16 !== {e.sum, e.cout, e.ovf}) begin
                errors++;
                $display("FAIL sweep_chunk16 v%0d: got lat=%0d res=%h expected lat=1 res=%h",
                         v, lat16, r16, {e.sum, e.cout, e.ovf});
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cin = 1'b0; sub = 1'b0; a = '0; b = '0;
        @(negedge clk);
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_subtract();
        test_overflow();
        test_abort();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
